// File: rtl/sha256_nonce_sweeper.sv
// Nonce sweeper that feeds the SHA-256 double-hash core and scores each digest against a target.
// Optional SWEEP_STATS_EN adds hash_count / last_nonce statistics outputs.
module sha256_nonce_sweeper #(
    parameter int unsigned CORE_LATENCY = 200,
    parameter int unsigned CNT_W        = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         job_valid,
    output logic         job_ready,
    input  logic [607:0] job_header,
    input  logic [255:0] job_target,
    input  logic [31:0]  nonce_start,
    input  logic [31:0]  nonce_end,
    input  logic         abort,
    output logic         core_reset,
    output logic [639:0] core_header,
    input  logic [255:0] core_digest,
    output logic         res_valid,
    input  logic         res_ready,
    output logic         res_found,
    output logic [31:0]  res_nonce,
    output logic [255:0] res_hash,
`ifdef SWEEP_STATS_EN
    output logic [47:0]  hash_count,
    output logic [31:0]  last_nonce,
`endif
    output logic         busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_CHECK,
        S_RESULT
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CORE_LATENCY - 1);

    state_t             state, state_next;
    logic [607:0]       hdr_q;
    logic [255:0]       target_q;
    logic [31:0]        nonce_q;
    logic [31:0]        end_q;
    logic [CNT_W-1:0]   cnt;
    logic [255:0]       score;
    logic               hit;
    logic               last_try;
    logic               aborting;

    function automatic logic [255:0] bswap256(input logic [255:0] d);
        logic [255:0] r;
        r = '0;
        for (int unsigned i = 0; i < 32; i++) begin
            r[8*i +: 8] = d[255-8*i -: 8];
        end
        return r;
    endfunction

    assign core_header = {hdr_q, nonce_q[7:0], nonce_q[15:8], nonce_q[23:16], nonce_q[31:24]};
    assign score       = bswap256(core_digest);
    assign hit         = (score <= target_q);
    assign last_try    = (nonce_q == end_q);
    assign aborting    = abort && (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:   if (job_valid) state_next = S_LAUNCH;
            S_LAUNCH: state_next = S_WAIT;
            S_WAIT:   if (cnt == CNT_LAST) state_next = S_CHECK;
            S_CHECK:  state_next = (hit || last_try) ? S_RESULT : S_LAUNCH;
            S_RESULT: if (res_ready) state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
        if (aborting) begin
            state_next = S_IDLE;
        end
    end

    always_comb begin
        job_ready = (state == S_IDLE);
        busy      = (state != S_IDLE);
    end

    // The core is held out of reset through CHECK so its digest is still valid when captured.
    always_ff @(posedge clk) begin
        if (reset) begin
            core_reset <= 1'b1;
            hdr_q      <= '0;
            target_q   <= '0;
            nonce_q    <= '0;
            end_q      <= '0;
            cnt        <= '0;
            res_valid  <= 1'b0;
            res_found  <= 1'b0;
            res_nonce  <= '0;
            res_hash   <= '0;
        end else begin
            core_reset <= !((state_next == S_WAIT) || (state_next == S_CHECK));
            case (state)
                S_IDLE: begin
                    if (job_valid) begin
                        hdr_q    <= job_header;
                        target_q <= job_target;
                        nonce_q  <= nonce_start;
                        end_q    <= nonce_end;
                    end
                end
                S_LAUNCH: cnt <= '0;
                S_WAIT:   cnt <= cnt + CNT_W'(1);
                S_CHECK: begin
                    if (!abort) begin
                        if (hit || last_try) begin
                            res_hash  <= score;
                            res_nonce <= nonce_q;
                            res_found <= hit;
                            res_valid <= 1'b1;
                        end else begin
                            nonce_q <= nonce_q + 32'd1;
                        end
                    end
                end
                S_RESULT: begin
                    if (abort || res_ready) begin
                        res_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef SWEEP_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            hash_count <= '0;
            last_nonce <= '0;
        end else if (state == S_IDLE && job_valid) begin
            hash_count <= '0;
        end else if (state == S_CHECK) begin
            hash_count <= hash_count + 48'd1;
            last_nonce <= nonce_q;
        end
    end
`endif

endmodule

// File: tb/tb_sha256_nonce_sweeper.sv
// Directed bench for sha256_nonce_sweeper with a behavioural stand-in for the hashing core.
// Build with +define+SWEEP_STATS_EN to also exercise the statistics outputs.
module tb_sha256_nonce_sweeper;

    localparam int unsigned LAT = 8;
    localparam int unsigned PERIOD = LAT + 2;

    localparam logic [607:0] GEN_HDR = 608'h0100000000000000000000000000000000000000000000000000000000000000000000003ba3edfd7a7b12b27ac72c3e67768f617fc81bc3888a51323a9fb8aa4b1e5e4a29ab5f49ffff001d;
    localparam logic [255:0] GEN_DIGEST = 256'h6fe28c0ab6f1b372c1a6a246ae63f74f931e8365e15a089c68d6190000000000;
    localparam logic [255:0] GEN_HASH   = 256'h000000000019D6689C085AE165831E934FF763AE46A2A6C172B3F1B60A8CE26F;
    localparam logic [255:0] GEN_TARGET = 256'hFFFF << 208;
    localparam logic [255:0] MISS_DIGEST = {8{32'hDEADBEEF}};
    localparam logic [255:0] MISS_HASH   = {8{32'hEFBEADDE}};

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         job_valid = 1'b0;
    logic         job_ready;
    logic [607:0] job_header = '0;
    logic [255:0] job_target = '0;
    logic [31:0]  nonce_start = '0;
    logic [31:0]  nonce_end = '0;
    logic         abort = 1'b0;
    logic         core_reset;
    logic [639:0] core_header;
    logic [255:0] core_digest;
    logic         res_valid;
    logic         res_ready = 1'b0;
    logic         res_found;
    logic [31:0]  res_nonce;
    logic [255:0] res_hash;
    logic         busy;
`ifdef SWEEP_STATS_EN
    logic [47:0]  hash_count;
    logic [31:0]  last_nonce;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sha256_nonce_sweeper #(.CORE_LATENCY(LAT), .CNT_W(4)) dut (
        .clk(clk), .reset(reset),
        .job_valid(job_valid), .job_ready(job_ready),
        .job_header(job_header), .job_target(job_target),
        .nonce_start(nonce_start), .nonce_end(nonce_end),
        .abort(abort),
        .core_reset(core_reset), .core_header(core_header), .core_digest(core_digest),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_found(res_found), .res_nonce(res_nonce), .res_hash(res_hash),
`ifdef SWEEP_STATS_EN
        .hash_count(hash_count), .last_nonce(last_nonce),
`endif
        .busy(busy)
    );

    // Core stand-in: digest appears LAT cycles after core_reset drops; zero before then.
    int mcnt = 0;
    always @(posedge clk) begin
        if (core_reset) mcnt <= 0;
        else if (mcnt < LAT) mcnt <= mcnt + 1;
    end
    always_comb begin
        if (mcnt < LAT) core_digest = '0;
        else if (core_header == {GEN_HDR, 32'h1DAC2B7C}) core_digest = GEN_DIGEST;
        else core_digest = MISS_DIGEST;
    end

    // Log serialized nonce field of every core launch.
    logic [31:0] launches[$];
    logic prev_cr = 1'b1;
    always @(posedge clk) begin
        if (prev_cr && !core_reset) launches.push_back(core_header[31:0]);
        prev_cr <= core_reset;
    end

    task automatic start_job(input logic [607:0] h, input logic [255:0] t,
                             input logic [31:0] s, input logic [31:0] e);
        launches.delete();
        job_header = h; job_target = t; nonce_start = s; nonce_end = e;
        job_valid = 1'b1;
        @(posedge clk); #1;
        job_valid = 1'b0;
        job_header = '1; job_target = '0; nonce_start = 32'h5555_5555; nonce_end = 32'hAAAA_AAAA;
    endtask

    task automatic wait_result(output int cycles);
        cycles = 0;
        while (!res_valid && cycles < 600) begin
            @(posedge clk); #1;
            cycles++;
        end
        if (!res_valid) begin
            failures++;
            $display("FAIL result_timeout: res_valid=%0b after %0d cycles, required 1", res_valid, cycles);
        end
    endtask

    task automatic accept_result();
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (core_reset !== 1'b1) begin failures++; $display("FAIL rst_core_reset: got %b want 1", core_reset); end
        checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL rst_res_valid: got %b want 0", res_valid); end
        checks++; if (res_found !== 1'b0) begin failures++; $display("FAIL rst_res_found: got %b want 0", res_found); end
        checks++; if (res_nonce !== 32'h0) begin failures++; $display("FAIL rst_res_nonce: got %h want 0", res_nonce); end
        checks++; if (res_hash !== 256'h0) begin failures++; $display("FAIL rst_res_hash: got %h want 0", res_hash); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy: got %b want 0", busy); end
        checks++; if (job_ready !== 1'b1) begin failures++; $display("FAIL rst_job_ready: got %b want 1", job_ready); end
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_genesis();
        int cyc;
        start_job(GEN_HDR, GEN_TARGET, 32'h7C2BAC1C, 32'h7C2BAC1E);
        wait_result(cyc);
        checks++; if (cyc != 2 * PERIOD) begin failures++; $display("FAIL gen_latency: got %0d cycles want %0d", cyc, 2 * PERIOD); end
        checks++; if (res_found !== 1'b1) begin failures++; $display("FAIL gen_found: got %b want 1", res_found); end
        checks++; if (res_nonce !== 32'h7C2BAC1D) begin failures++; $display("FAIL gen_nonce: got %h want 7c2bac1d", res_nonce); end
        checks++; if (res_hash !== GEN_HASH) begin failures++; $display("FAIL gen_hash: got %h want %h", res_hash, GEN_HASH); end
        checks++;
        if (launches.size() != 2 || launches[0] !== 32'h1CAC2B7C || launches[1] !== 32'h1DAC2B7C) begin
            failures++; $display("FAIL gen_launches: got %0d launches want 2 (1cac2b7c,1dac2b7c)", launches.size());
        end
        accept_result();
        checks++; if (job_ready !== 1'b1 || res_valid !== 1'b0) begin failures++; $display("FAIL gen_release: job_ready=%b res_valid=%b want 1,0", job_ready, res_valid); end
    endtask

    task automatic test_exhaust();
        int cyc;
        start_job(GEN_HDR, 256'h0, 32'h10, 32'h13);
        wait_result(cyc);
        checks++; if (cyc != 4 * PERIOD) begin failures++; $display("FAIL exh_latency: got %0d want %0d", cyc, 4 * PERIOD); end
        checks++;
        if (launches.size() != 4 || launches[0] !== 32'h10000000 || launches[1] !== 32'h11000000 ||
            launches[2] !== 32'h12000000 || launches[3] !== 32'h13000000) begin
            failures++; $display("FAIL exh_launches: got %0d launches want 4 (nonce 10..13)", launches.size());
        end
        checks++; if (res_found !== 1'b0) begin failures++; $display("FAIL exh_found: got %b want 0", res_found); end
        checks++; if (res_nonce !== 32'h13) begin failures++; $display("FAIL exh_nonce: got %h want 13", res_nonce); end
        checks++; if (res_hash !== MISS_HASH) begin failures++; $display("FAIL exh_hash: got %h want %h", res_hash, MISS_HASH); end
        accept_result();
    endtask

    task automatic test_wrap();
        int cyc;
        start_job(GEN_HDR, 256'h0, 32'hFFFFFFFE, 32'h00000001);
        wait_result(cyc);
        checks++;
        if (launches.size() != 4 || launches[0] !== 32'hFEFFFFFF || launches[1] !== 32'hFFFFFFFF ||
            launches[2] !== 32'h00000000 || launches[3] !== 32'h01000000) begin
            failures++; $display("FAIL wrap_launches: got %0d launches want 4 (fffffffe,ffffffff,0,1)", launches.size());
        end
        checks++; if (res_found !== 1'b0 || res_nonce !== 32'h1) begin failures++; $display("FAIL wrap_result: found=%b nonce=%h want 0,00000001", res_found, res_nonce); end
        accept_result();
    endtask

    task automatic test_backpressure();
        int cyc;
        logic [31:0] n0;
        logic [255:0] h0;
        logic f0;
        start_job(GEN_HDR, GEN_TARGET, 32'h7C2BAC1D, 32'h7C2BAC1D);
        wait_result(cyc);
        checks++; if (cyc != PERIOD || launches.size() != 1) begin failures++; $display("FAIL bp_single: got %0d cycles %0d launches want %0d,1", cyc, launches.size(), PERIOD); end
        n0 = res_nonce; h0 = res_hash; f0 = res_found;
        checks++; if (f0 !== 1'b1 || n0 !== 32'h7C2BAC1D || h0 !== GEN_HASH) begin failures++; $display("FAIL bp_result: found=%b nonce=%h want 1,7c2bac1d", f0, n0); end
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            checks++;
            if (res_valid !== 1'b1 || job_ready !== 1'b0 || res_nonce !== n0 || res_hash !== h0 || res_found !== f0) begin
                failures++; $display("FAIL bp_hold cycle %0d: valid=%b job_ready=%b nonce=%h want 1,0,%h", i, res_valid, job_ready, res_nonce, n0);
            end
        end
        accept_result();
        checks++; if (job_ready !== 1'b1 || busy !== 1'b0 || res_valid !== 1'b0) begin failures++; $display("FAIL bp_idle: job_ready=%b busy=%b valid=%b want 1,0,0", job_ready, busy, res_valid); end
    endtask

    task automatic test_abort();
        int cyc;
        int seen_valid;
        start_job(GEN_HDR, 256'h0, 32'h20, 32'h23);
        cyc = 0;
        while (launches.size() < 2 && cyc < 100) begin @(posedge clk); #1; cyc++; end
        checks++; if (launches.size() != 2) begin failures++; $display("FAIL abort_reach: got %0d launches want 2", launches.size()); end
        repeat (3) begin @(posedge clk); #1; end
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        checks++; if (busy !== 1'b0 || core_reset !== 1'b1 || res_valid !== 1'b0) begin failures++; $display("FAIL abort_idle: busy=%b core_reset=%b valid=%b want 0,1,0", busy, core_reset, res_valid); end
        seen_valid = 0;
        repeat (30) begin @(posedge clk); #1; if (res_valid || busy) seen_valid++; end
        checks++; if (seen_valid != 0) begin failures++; $display("FAIL abort_quiet: got %0d active cycles want 0", seen_valid); end
        start_job(GEN_HDR, GEN_TARGET, 32'h7C2BAC1D, 32'h7C2BAC1D);
        wait_result(cyc);
        checks++; if (res_found !== 1'b1 || res_nonce !== 32'h7C2BAC1D || cyc != PERIOD) begin failures++; $display("FAIL abort_next_job: found=%b nonce=%h cycles=%0d want 1,7c2bac1d,%0d", res_found, res_nonce, cyc, PERIOD); end
        accept_result();
    endtask

    task automatic test_reset_mid();
        int cyc;
        start_job(GEN_HDR, 256'h0, 32'h30, 32'h32);
        wait_result(cyc);
        checks++; if (res_found !== 1'b0 || res_nonce !== 32'h32) begin failures++; $display("FAIL mid_prejob: found=%b nonce=%h want 0,00000032", res_found, res_nonce); end
`ifdef SWEEP_STATS_EN
        checks++; if (hash_count !== 48'd3) begin failures++; $display("FAIL stats_count: got %0d want 3", hash_count); end
        checks++; if (last_nonce !== 32'h32) begin failures++; $display("FAIL stats_last: got %h want 00000032", last_nonce); end
`endif
        accept_result();
        start_job(GEN_HDR, 256'h0, 32'h40, 32'h45);
        repeat (PERIOD + 4) begin @(posedge clk); #1; end
        reset = 1'b1;
        @(posedge clk); #1;
        checks++; if (core_reset !== 1'b1) begin failures++; $display("FAIL mid_core_reset: got %b want 1", core_reset); end
        checks++; if (res_valid !== 1'b0 || res_found !== 1'b0) begin failures++; $display("FAIL mid_res_flags: valid=%b found=%b want 0,0", res_valid, res_found); end
        checks++; if (res_nonce !== 32'h0 || res_hash !== 256'h0) begin failures++; $display("FAIL mid_res_data: nonce=%h want 0", res_nonce); end
        checks++; if (busy !== 1'b0 || job_ready !== 1'b1) begin failures++; $display("FAIL mid_state: busy=%b job_ready=%b want 0,1", busy, job_ready); end
`ifdef SWEEP_STATS_EN
        checks++; if (hash_count !== 48'd0) begin failures++; $display("FAIL stats_reset: got %0d want 0", hash_count); end
`endif
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_genesis();
        test_exhaust();
        test_wrap();
        test_backpressure();
        test_abort();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
